// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and constants for the two-master memory bus arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } arb_state_t;

    typedef enum logic [1:0] {
        NONE = 2'b00,
        M0   = 2'b01,
        M1   = 2'b10
    } owner_t;

    localparam logic [7:0] ERR_RDATA = 8'hFF;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Read/write/ready memory port; the master issues accesses, the slave completes them.
interface mem_bus_arbiter_if;

    logic [15:0] addr;
    logic [7:0]  wdata;
    logic        read;
    logic        write;
    logic [7:0]  rdata;
    logic        ready;
    logic        error;

    // Downstream memory has no error signal, so the master side does not see it.
    modport master (
        output addr, wdata, read, write,
        input  rdata, ready
    );

    modport slave (
        input  addr, wdata, read, write,
        output rdata, ready, error
    );

endinterface

// File: rtl/mem_bus_arbiter_priority_sel.sv
// Fixed-priority winner select for m0 over m1, with a run counter that forces
// an m1 grant after MAX_M0_RUN back-to-back m0 grants made while m1 waited.
module arb_priority_sel
    import mem_arb_pkg::*;
#(
    parameter int MAX_M0_RUN = 4
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   m0_req,
    input  logic   m1_req,
    input  logic   grant,
    output owner_t winner
);

    localparam logic [3:0] RUN_MAX = 4'(MAX_M0_RUN);

    logic [3:0] run_cnt;

    always_comb begin
        winner = NONE;
        if (m0_req && !(m1_req && run_cnt == RUN_MAX)) begin
            winner = M0;
        end else if (m1_req) begin
            winner = M1;
        end
    end

    // Counter only moves when a grant actually happens in IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_cnt <= 4'd0;
        end else if (grant && winner != NONE) begin
            if (winner == M0 && m1_req) begin
                if (run_cnt != RUN_MAX) begin
                    run_cnt <= run_cnt + 4'd1;
                end
            end else begin
                run_cnt <= 4'd0;
            end
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-master arbiter in front of the memory controller: IDLE -> BUSY -> DONE,
// registered downstream strobes, one-cycle ready pulse and access timeout.
module mem_bus_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MAX_M0_RUN     = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    mem_bus_arbiter_if.slave  m0,
    mem_bus_arbiter_if.slave  m1,
    mem_bus_arbiter_if.master s,
    output logic [1:0]        dbg_owner,
    output logic [1:0]        dbg_state
);

    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_BUSY = BUSY;
    localparam logic [1:0] ST_DONE = DONE;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [1:0]    state;
    owner_t        owner;
    owner_t        winner;
    logic [TW-1:0] tmo_cnt;

    logic [15:0] s_addr_q;
    logic [7:0]  s_wdata_q;
    logic        s_read_q;
    logic        s_write_q;
    logic [7:0]  m0_rdata_q;
    logic        m0_ready_q;
    logic        m0_error_q;
    logic [7:0]  m1_rdata_q;
    logic        m1_ready_q;
    logic        m1_error_q;

    logic [15:0] sel_addr;
    logic [7:0]  sel_wdata;
    logic        sel_write;
    logic [7:0]  cap_rdata;

    arb_priority_sel #(
        .MAX_M0_RUN(MAX_M0_RUN)
    ) u_sel (
        .clk    (clk),
        .rst_n  (rst_n),
        .m0_req (m0.read | m0.write),
        .m1_req (m1.read | m1.write),
        .grant  (state == ST_IDLE),
        .winner (winner)
    );

    always_comb begin
        sel_addr  = m0.addr;
        sel_wdata = m0.wdata;
        sel_write = m0.write;
        if (winner == M1) begin
            sel_addr  = m1.addr;
            sel_wdata = m1.wdata;
            sel_write = m1.write;
        end
    end

    assign cap_rdata = s_write_q ? 8'h00 : s.rdata;

    // Ready/error default low so they are single-cycle pulses during DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            owner      <= NONE;
            tmo_cnt    <= '0;
            s_addr_q   <= 16'h0000;
            s_wdata_q  <= 8'h00;
            s_read_q   <= 1'b0;
            s_write_q  <= 1'b0;
            m0_rdata_q <= 8'h00;
            m0_ready_q <= 1'b0;
            m0_error_q <= 1'b0;
            m1_rdata_q <= 8'h00;
            m1_ready_q <= 1'b0;
            m1_error_q <= 1'b0;
        end else begin
            m0_ready_q <= 1'b0;
            m0_error_q <= 1'b0;
            m1_ready_q <= 1'b0;
            m1_error_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (winner != NONE) begin
                        owner     <= winner;
                        s_addr_q  <= sel_addr;
                        s_wdata_q <= sel_wdata;
                        s_write_q <= sel_write;
                        s_read_q  <= ~sel_write;
                        tmo_cnt   <= '0;
                        state     <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    tmo_cnt <= tmo_cnt + TW'(1);
                    if (s.ready) begin
                        s_read_q  <= 1'b0;
                        s_write_q <= 1'b0;
                        if (owner == M1) begin
                            m1_rdata_q <= cap_rdata;
                            m1_ready_q <= 1'b1;
                        end else begin
                            m0_rdata_q <= cap_rdata;
                            m0_ready_q <= 1'b1;
                        end
                        state <= ST_DONE;
                    end else if (tmo_cnt == TMO_LAST) begin
                        s_addr_q  <= 16'h0000;
                        s_wdata_q <= 8'h00;
                        s_read_q  <= 1'b0;
                        s_write_q <= 1'b0;
                        if (owner == M1) begin
                            m1_rdata_q <= ERR_RDATA;
                            m1_ready_q <= 1'b1;
                            m1_error_q <= 1'b1;
                        end else begin
                            m0_rdata_q <= ERR_RDATA;
                            m0_ready_q <= 1'b1;
                            m0_error_q <= 1'b1;
                        end
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    owner <= NONE;
                    state <= ST_IDLE;
                end
                default: begin
                    owner <= NONE;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign s.addr   = s_addr_q;
    assign s.wdata  = s_wdata_q;
    assign s.read   = s_read_q;
    assign s.write  = s_write_q;
    assign m0.rdata = m0_rdata_q;
    assign m0.ready = m0_ready_q;
    assign m0.error = m0_error_q;
    assign m1.rdata = m1_rdata_q;
    assign m1.ready = m1_ready_q;
    assign m1.error = m1_error_q;

    assign dbg_owner = owner;
    assign dbg_state = state;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter with MAX_M0_RUN=4 and TIMEOUT_CYCLES=8.
module tb_mem_bus_arbiter;

    logic       clk;
    logic       rst_n;
    logic [1:0] dbg_owner;
    logic [1:0] dbg_state;
    int         checks;
    int         errors;
    logic [1:0] grant_seq [10];

    mem_bus_arbiter_if m0_bus ();
    mem_bus_arbiter_if m1_bus ();
    mem_bus_arbiter_if s_bus ();

    mem_bus_arbiter #(
        .MAX_M0_RUN     (4),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .m0        (m0_bus),
        .m1        (m1_bus),
        .s         (s_bus),
        .dbg_owner (dbg_owner),
        .dbg_state (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic m0r, input logic m0w, input logic [15:0] m0a, input logic [7:0] m0d,
                                  input logic m1r, input logic m1w, input logic [15:0] m1a, input logic [7:0] m1d);
        m0_bus.read  = m0r;
        m0_bus.write = m0w;
        m0_bus.addr  = m0a;
        m0_bus.wdata = m0d;
        m1_bus.read  = m1r;
        m1_bus.write = m1w;
        m1_bus.addr  = m1a;
        m1_bus.wdata = m1d;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        grant_seq = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b01, 2'b01, 2'b01, 2'b01, 2'b10};
        rst_n = 1'b0;
        s_bus.ready = 1'b0;
        s_bus.rdata = 8'h00;
        s_bus.error = 1'b0;
        apply_stimulus(0, 0, 16'h0, 8'h0, 0, 0, 16'h0, 8'h0);
        #12;
        check_output("rst_s_read", s_bus.read, 0);
        check_output("rst_s_addr", s_bus.addr, 0);
        check_output("rst_m0_ready", m0_bus.ready, 0);
        check_output("rst_m0_rdata", m0_bus.rdata, 0);
        check_output("rst_owner", dbg_owner, 0);
        check_output("rst_state", dbg_state, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Single m0 read, zero-wait downstream
        apply_stimulus(1, 0, 16'h8000, 8'h00, 0, 0, 16'h0, 8'h0);
        s_bus.ready = 1'b1;
        s_bus.rdata = 8'h42;
        step();
        check_output("rd_s_read", s_bus.read, 1);
        check_output("rd_s_addr", s_bus.addr, 16'h8000);
        check_output("rd_owner", dbg_owner, 2'b01);
        check_output("rd_state_busy", dbg_state, 1);
        check_output("rd_ready_early", m0_bus.ready, 0);
        step();
        check_output("rd_m0_ready", m0_bus.ready, 1);
        check_output("rd_m0_rdata", m0_bus.rdata, 8'h42);
        check_output("rd_m0_error", m0_bus.error, 0);
        check_output("rd_s_read_drop", s_bus.read, 0);
        check_output("rd_state_done", dbg_state, 2);
        apply_stimulus(0, 0, 16'h0, 8'h0, 0, 0, 16'h0, 8'h0);
        step();
        check_output("rd_idle_ready", m0_bus.ready, 0);
        check_output("rd_idle_owner", dbg_owner, 0);

        // Both masters reading back-to-back: starvation guard
        apply_stimulus(1, 0, 16'h1000, 8'h00, 1, 0, 16'h2000, 8'h00);
        for (int i = 0; i < 10; i++) begin
            step();
            check_output($sformatf("arb_owner_%0d", i), dbg_owner, grant_seq[i]);
            s_bus.rdata = 8'(8'h10 + i);
            step();
            check_output($sformatf("arb_m0_ready_%0d", i), m0_bus.ready, grant_seq[i] == 2'b01);
            check_output($sformatf("arb_m1_ready_%0d", i), m1_bus.ready, grant_seq[i] == 2'b10);
            check_output($sformatf("arb_rdata_%0d", i),
                         (grant_seq[i] == 2'b01) ? m0_bus.rdata : m1_bus.rdata, 8'(8'h10 + i));
            step();
        end
        apply_stimulus(0, 0, 16'h0, 8'h0, 0, 0, 16'h0, 8'h0);

        // m1 write alone
        apply_stimulus(0, 0, 16'h0, 8'h0, 0, 1, 16'h0200, 8'h55);
        step();
        check_output("wr_s_write", s_bus.write, 1);
        check_output("wr_s_read", s_bus.read, 0);
        check_output("wr_s_addr", s_bus.addr, 16'h0200);
        check_output("wr_s_wdata", s_bus.wdata, 8'h55);
        check_output("wr_owner", dbg_owner, 2'b10);
        check_output("wr_m0_ready_busy", m0_bus.ready, 0);
        step();
        check_output("wr_m1_ready", m1_bus.ready, 1);
        check_output("wr_m1_rdata", m1_bus.rdata, 8'h00);
        check_output("wr_m0_ready_done", m0_bus.ready, 0);
        check_output("wr_m0_rdata_hold", m0_bus.rdata, 8'h18);
        apply_stimulus(0, 0, 16'h0, 8'h0, 0, 0, 16'h0, 8'h0);
        step();
        check_output("wr_m1_ready_clr", m1_bus.ready, 0);

        // m0 read timing out after 8 BUSY cycles
        s_bus.ready = 1'b0;
        apply_stimulus(1, 0, 16'h1234, 8'h00, 0, 0, 16'h0, 8'h0);
        step();
        check_output("to_s_read", s_bus.read, 1);
        for (int k = 2; k <= 8; k++) begin
            step();
            check_output($sformatf("to_busy_%0d", k), dbg_state, 1);
            check_output($sformatf("to_ready_%0d", k), m0_bus.ready, 0);
        end
        step();
        check_output("to_m0_ready", m0_bus.ready, 1);
        check_output("to_m0_error", m0_bus.error, 1);
        check_output("to_m0_rdata", m0_bus.rdata, 8'hFF);
        check_output("to_s_read_drop", s_bus.read, 0);
        apply_stimulus(0, 0, 16'h0, 8'h0, 0, 0, 16'h0, 8'h0);
        step();
        check_output("to_error_clr", m0_bus.error, 0);

        // s_ready arriving on the last timeout cycle wins
        apply_stimulus(1, 0, 16'h1235, 8'h00, 0, 0, 16'h0, 8'h0);
        step();
        for (int k = 2; k <= 8; k++) begin
            step();
        end
        s_bus.ready = 1'b1;
        s_bus.rdata = 8'h3C;
        step();
        check_output("tie_m0_ready", m0_bus.ready, 1);
        check_output("tie_m0_error", m0_bus.error, 0);
        check_output("tie_m0_rdata", m0_bus.rdata, 8'h3C);
        apply_stimulus(0, 0, 16'h0, 8'h0, 0, 0, 16'h0, 8'h0);
        step();

        // read and write together becomes a write
        apply_stimulus(1, 1, 16'h4000, 8'hA5, 0, 0, 16'h0, 8'h0);
        step();
        check_output("rw_s_write", s_bus.write, 1);
        check_output("rw_s_read", s_bus.read, 0);
        check_output("rw_s_wdata", s_bus.wdata, 8'hA5);
        step();
        check_output("rw_m0_rdata", m0_bus.rdata, 8'h00);
        apply_stimulus(0, 0, 16'h0, 8'h0, 0, 0, 16'h0, 8'h0);
        step();

        // Reset in the middle of BUSY
        s_bus.ready = 1'b0;
        apply_stimulus(1, 0, 16'h0777, 8'h00, 0, 0, 16'h0, 8'h0);
        step();
        check_output("mr_s_read_pre", s_bus.read, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_output("mr_s_read", s_bus.read, 0);
        check_output("mr_s_addr", s_bus.addr, 0);
        check_output("mr_owner", dbg_owner, 0);
        check_output("mr_state", dbg_state, 0);
        check_output("mr_m0_rdata", m0_bus.rdata, 0);
        step();
        check_output("mr_m0_ready", m0_bus.ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        s_bus.ready = 1'b1;
        s_bus.rdata = 8'h77;
        apply_stimulus(1, 0, 16'h0010, 8'h00, 0, 0, 16'h0, 8'h0);
        step();
        check_output("mr_post_addr", s_bus.addr, 16'h0010);
        check_output("mr_post_owner", dbg_owner, 2'b01);
        step();
        check_output("mr_post_ready", m0_bus.ready, 1);
        check_output("mr_post_rdata", m0_bus.rdata, 8'h77);
        apply_stimulus(0, 0, 16'h0, 8'h0, 0, 0, 16'h0, 8'h0);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
